// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback queue.
// Entry layout, producer ids and default widths.
package rf_wb_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_AW    = 5;
    localparam int RF_DEPTH = 4;

    typedef struct packed {
        logic [RF_AW-1:0]   rd;
        logic [RF_XLEN-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_LD,
        SRC_MD
    } src_e;

    // Two writes to the same real register cannot share a cycle.
    function automatic logic rd_conflict(
        input logic [RF_AW-1:0] a,
        input logic [RF_AW-1:0] b
    );
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/wb_queue_mem.sv
// Storage array for the writeback queue.
// Three append ports from tail, two read ports from head.
module wb_queue_mem
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic [PW-1:0]            tail_i,
    input  logic [2:0]               wen_i,
    input  wb_entry_t                wdata_i [3],
    input  logic [PW-1:0]            head_i,
    output wb_entry_t                rd0_o,
    output wb_entry_t                rd1_o,
    output logic [DEPTH*ENTRY_W-1:0] flat_o
);

    wb_entry_t mem_q [DEPTH];

    // Append accepted results at tail, tail+1, tail+2.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wen_i[k]) begin
                mem_q[tail_i + PW'(k)] <= wdata_i[k];
            end
        end
    end

    assign rd0_o = mem_q[head_i];
    assign rd1_o = mem_q[head_i + PW'(1)];

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign flat_o[i*ENTRY_W +: ENTRY_W] = mem_q[i];
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue feeding regfile write ports 3 and 4.
// Merges ALU/LD/MD results in order, retires two per cycle.
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int XLEN  = RF_XLEN,
    parameter int AW    = RF_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [AW-1:0]          ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   md_valid,
    output logic                   md_ready,
    input  logic [AW-1:0]          md_rd,
    input  logic [XLEN-1:0]        md_data,
    output logic                   we3,
    output logic [AW-1:0]          wa3,
    output logic [XLEN-1:0]        wd3,
    output logic                   we4,
    output logic [AW-1:0]          wa4,
    output logic [XLEN-1:0]        wd4,
    input  logic [AW-1:0]          ra1,
    input  logic [AW-1:0]          ra2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [XLEN-1:0]        fwd1,
    output logic [XLEN-1:0]        fwd2,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;

    logic          acc_alu, acc_ld, acc_md;
    logic [1:0]    n_acc, n_ret, slot;
    logic          ret3, ret4;

    wb_entry_t     alu_e, ld_e, md_e;
    wb_entry_t     wdata [3];
    src_e          wsrc [3];
    logic [2:0]    wen;
    wb_entry_t     e0, e1;
    wb_entry_t     ents [DEPTH];
    logic [DEPTH*ENTRY_W-1:0] flat;

    assign alu_e = '{rd: alu_rd, data: alu_data};
    assign ld_e  = '{rd: ld_rd,  data: ld_data};
    assign md_e  = '{rd: md_rd,  data: md_data};

    // Space is judged on registered occupancy only.
    assign free = CW'(DEPTH) - count_q;

    // Fixed priority ALU > LD > MD over the free slots.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        md_ready  = 1'b0;
        if (!reset) begin
            alu_ready = free >= CW'(1);
            ld_ready  = free >= CW'(1) + CW'(alu_valid);
            md_ready  = free >= CW'(1) + CW'(alu_valid)
                              + CW'(ld_valid);
        end
    end

    assign acc_alu = alu_valid & alu_ready;
    assign acc_ld  = ld_valid  & ld_ready;
    assign acc_md  = md_valid  & md_ready;
    assign n_acc   = 2'(acc_alu) + 2'(acc_ld) + 2'(acc_md);

    // Pack this cycle's acceptances into consecutive slots.
    always_comb begin
        wen  = '0;
        slot = '0;
        for (int k = 0; k < 3; k++) begin
            wsrc[k] = SRC_ALU;
        end
        if (acc_alu) begin
            wen[slot]  = 1'b1;
            wsrc[slot] = SRC_ALU;
            slot       = slot + 2'd1;
        end
        if (acc_ld) begin
            wen[slot]  = 1'b1;
            wsrc[slot] = SRC_LD;
            slot       = slot + 2'd1;
        end
        if (acc_md) begin
            wen[slot]  = 1'b1;
            wsrc[slot] = SRC_MD;
        end
    end

    // Route each slot's producer onto its write port.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            wdata[k] = alu_e;
            unique case (wsrc[k])
                SRC_ALU: wdata[k] = alu_e;
                SRC_LD:  wdata[k] = ld_e;
                SRC_MD:  wdata[k] = md_e;
                default: wdata[k] = alu_e;
            endcase
        end
    end

    wb_queue_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .tail_i  (tail_q),
        .wen_i   (wen),
        .wdata_i (wdata),
        .head_i  (head_q),
        .rd0_o   (e0),
        .rd1_o   (e1),
        .flat_o  (flat)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_ents
        assign ents[i] = flat[i*ENTRY_W +: ENTRY_W];
    end

    // Head always retires; second entry waits on a same-rd clash.
    always_comb begin
        ret3 = 1'b0;
        ret4 = 1'b0;
        if (!reset) begin
            ret3 = count_q >= CW'(1);
            ret4 = (count_q >= CW'(2))
                && !rd_conflict(e0.rd, e1.rd);
        end
    end

    assign n_ret = 2'(ret3) + 2'(ret4);

    // x0 entries use a slot but never write.
    always_comb begin
        we3 = ret3 && (e0.rd != '0);
        wa3 = ret3 ? e0.rd   : '0;
        wd3 = ret3 ? e0.data : '0;
        we4 = ret4 && (e1.rd != '0);
        wa4 = ret4 ? e1.rd   : '0;
        wd4 = ret4 ? e1.data : '0;
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (ra1 != '0 && ents[head_q + PW'(i)].rd == ra1) begin
                    hit1 = 1'b1;
                    fwd1 = ents[head_q + PW'(i)].data;
                end
                if (ra2 != '0 && ents[head_q + PW'(i)].rd == ra2) begin
                    hit2 = 1'b1;
                    fwd2 = ents[head_q + PW'(i)].data;
                end
            end
        end
        if (reset) begin
            hit1 = 1'b0;
            hit2 = 1'b0;
            fwd1 = '0;
            fwd2 = '0;
        end
    end

    assign head_d  = head_q + PW'(n_ret);
    assign tail_d  = tail_q + PW'(n_acc);
    assign count_d = count_q + CW'(n_acc) - CW'(n_ret);

    // Pointer and occupancy state; reset drops every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue.
// Hand vectors plus an in-order scoreboard for the fill run.
module tb_rf_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, md_valid;
    logic        alu_ready, ld_ready, md_ready;
    logic [4:0]  alu_rd, ld_rd, md_rd;
    logic [31:0] alu_data, ld_data, md_data;
    logic        we3, we4;
    logic [4:0]  wa3, wa4;
    logic [31:0] wd3, wd4;
    logic [4:0]  ra1, ra2;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;

    int ncmp = 0;
    int nerr = 0;

    logic [4:0]  mrd [$];
    logic [31:0] mdat [$];

    always #5 clk = ~clk;

    rf_wb_queue dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_rd     (md_rd),
        .md_data   (md_data),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .we4       (we4),
        .wa4       (wa4),
        .wd4       (wd4),
        .ra1       (ra1),
        .ra2       (ra2),
        .hit1      (hit1),
        .hit2      (hit2),
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .count     (count)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        md_valid  = 1'b0;
    endtask

    // Expected port 3/4 and count from the scoreboard queue.
    task automatic check_ports(input string tag, output int nret);
        logic        s3, s4;
        logic [4:0]  a3, a4;
        logic [31:0] d3, d4;
        s3 = mrd.size() >= 1;
        s4 = mrd.size() >= 2;
        if (s4) s4 = !(mrd[0] == mrd[1] && mrd[0] != 5'd0);
        a3 = s3 ? mrd[0]  : 5'd0;
        d3 = s3 ? mdat[0] : 32'd0;
        a4 = s4 ? mrd[1]  : 5'd0;
        d4 = s4 ? mdat[1] : 32'd0;
        chk({tag, ".count"}, 64'(count), 64'(mrd.size()));
        chk({tag, ".we3"}, 64'(we3), 64'(s3 && a3 != 5'd0));
        chk({tag, ".wa3"}, 64'(wa3), 64'(a3));
        chk({tag, ".wd3"}, 64'(wd3), 64'(d3));
        chk({tag, ".we4"}, 64'(we4), 64'(s4 && a4 != 5'd0));
        chk({tag, ".wa4"}, 64'(wa4), 64'(a4));
        chk({tag, ".wd4"}, 64'(wd4), 64'(d4));
        nret = int'(s3) + int'(s4);
    endtask

    initial begin
        int nret;
        int fr;
        logic er_a, er_l, er_m;

        reset = 1'b1;
        idle_inputs();
        alu_rd = '0; alu_data = '0;
        ld_rd  = '0; ld_data  = '0;
        md_rd  = '0; md_data  = '0;
        ra1 = '0; ra2 = '0;

        // 1: reset held two cycles
        for (int c = 0; c < 2; c++) begin
            tick();
            alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1;
            #1;
            chk("rst.alu_ready", 64'(alu_ready), 64'(0));
            chk("rst.ld_ready", 64'(ld_ready), 64'(0));
            chk("rst.md_ready", 64'(md_ready), 64'(0));
            chk("rst.we3", 64'(we3), 64'(0));
            chk("rst.we4", 64'(we4), 64'(0));
            idle_inputs();
        end
        tick();
        reset = 1'b0;
        #1;
        chk("post.count", 64'(count), 64'(0));
        chk("post.alu_ready", 64'(alu_ready), 64'(1));
        chk("post.ld_ready", 64'(ld_ready), 64'(1));
        chk("post.md_ready", 64'(md_ready), 64'(1));

        // 2: ALU and LD in the same cycle, both retire together
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h4242_4242;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'hdead_beef;
        #1;
        chk("t2.alu_ready", 64'(alu_ready), 64'(1));
        chk("t2.ld_ready", 64'(ld_ready), 64'(1));
        tick();
        idle_inputs();
        #1;
        chk("t2.count", 64'(count), 64'(2));
        chk("t2.we3", 64'(we3), 64'(1));
        chk("t2.wa3", 64'(wa3), 64'(1));
        chk("t2.wd3", 64'(wd3), 64'(32'h4242_4242));
        chk("t2.we4", 64'(we4), 64'(1));
        chk("t2.wa4", 64'(wa4), 64'(2));
        chk("t2.wd4", 64'(wd4), 64'(32'hdead_beef));
        tick();
        chk("t2.count0", 64'(count), 64'(0));
        chk("t2.idle.wa3", 64'(wa3), 64'(0));
        chk("t2.idle.wd3", 64'(wd3), 64'(0));

        // 3: same rd twice serialises, lookup sees the younger
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd5; ld_data  = 32'h2;
        tick();
        idle_inputs();
        ra1 = 5'd5; ra2 = 5'd6;
        #1;
        chk("t3a.we3", 64'(we3), 64'(1));
        chk("t3a.wa3", 64'(wa3), 64'(5));
        chk("t3a.wd3", 64'(wd3), 64'(1));
        chk("t3a.we4", 64'(we4), 64'(0));
        chk("t3a.wa4", 64'(wa4), 64'(0));
        chk("t3a.wd4", 64'(wd4), 64'(0));
        chk("t3a.hit1", 64'(hit1), 64'(1));
        chk("t3a.fwd1", 64'(fwd1), 64'(2));
        chk("t3a.hit2", 64'(hit2), 64'(0));
        chk("t3a.fwd2", 64'(fwd2), 64'(0));
        tick();
        chk("t3b.count", 64'(count), 64'(1));
        chk("t3b.we3", 64'(we3), 64'(1));
        chk("t3b.wa3", 64'(wa3), 64'(5));
        chk("t3b.wd3", 64'(wd3), 64'(2));
        chk("t3b.we4", 64'(we4), 64'(0));
        chk("t3b.fwd1", 64'(fwd1), 64'(2));
        tick();
        chk("t3c.count", 64'(count), 64'(0));
        chk("t3c.hit1", 64'(hit1), 64'(0));
        ra1 = '0; ra2 = '0;

        // 4: all producers valid every cycle vs scoreboard
        for (int c = 0; c < 6; c++) begin
            check_ports($sformatf("t4.c%0d", c), nret);
            alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1;
            alu_rd = 5'(8 + 3*c);
            ld_rd  = 5'(9 + 3*c);
            md_rd  = 5'(10 + 3*c);
            alu_data = 32'ha000_0000 | 32'(c << 4);
            ld_data  = 32'hb000_0000 | 32'(c << 4);
            md_data  = 32'hc000_0000 | 32'(c << 4);
            #1;
            fr   = 4 - mrd.size();
            er_a = fr >= 1;
            er_l = fr >= 2;
            er_m = fr >= 3;
            chk($sformatf("t4.c%0d.alu_ready", c),
                64'(alu_ready), 64'(er_a));
            chk($sformatf("t4.c%0d.ld_ready", c),
                64'(ld_ready), 64'(er_l));
            chk($sformatf("t4.c%0d.md_ready", c),
                64'(md_ready), 64'(er_m));
            for (int r = 0; r < nret; r++) begin
                void'(mrd.pop_front());
                void'(mdat.pop_front());
            end
            if (er_a) begin
                mrd.push_back(alu_rd); mdat.push_back(alu_data);
            end
            if (er_l) begin
                mrd.push_back(ld_rd); mdat.push_back(ld_data);
            end
            if (er_m) begin
                mrd.push_back(md_rd); mdat.push_back(md_data);
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            check_ports($sformatf("t4.drain%0d", c), nret);
            for (int r = 0; r < nret; r++) begin
                void'(mrd.pop_front());
                void'(mdat.pop_front());
            end
            tick();
        end
        chk("t4.empty", 64'(count), 64'(0));

        // 5: x0 entry takes a slot without writing
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hffff_ffff;
        tick();
        idle_inputs();
        ra1 = 5'd0;
        #1;
        chk("t5.count", 64'(count), 64'(1));
        chk("t5.we3", 64'(we3), 64'(0));
        chk("t5.wa3", 64'(wa3), 64'(0));
        chk("t5.wd3", 64'(wd3), 64'(32'hffff_ffff));
        chk("t5.hit1", 64'(hit1), 64'(0));
        chk("t5.fwd1", 64'(fwd1), 64'(0));
        tick();
        chk("t5.count0", 64'(count), 64'(0));

        // 6: reset with three entries queued
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h44;
        md_valid  = 1'b1; md_rd  = 5'd6; md_data  = 32'h66;
        tick();
        idle_inputs();
        chk("t6.count3", 64'(count), 64'(3));
        reset = 1'b1;
        ra1 = 5'd3; ra2 = 5'd4;
        #1;
        chk("t6.rst.we3", 64'(we3), 64'(0));
        chk("t6.rst.we4", 64'(we4), 64'(0));
        chk("t6.rst.hit1", 64'(hit1), 64'(0));
        chk("t6.rst.hit2", 64'(hit2), 64'(0));
        chk("t6.rst.alu_ready", 64'(alu_ready), 64'(0));
        tick();
        chk("t6.count0", 64'(count), 64'(0));
        reset = 1'b0;
        #1;
        chk("t6.rel.we3", 64'(we3), 64'(0));
        chk("t6.rel.we4", 64'(we4), 64'(0));
        chk("t6.rel.hit1", 64'(hit1), 64'(0));
        chk("t6.rel.hit2", 64'(hit2), 64'(0));
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        idle_inputs();
        ra1 = 5'd7;
        #1;
        chk("t6.new.count", 64'(count), 64'(1));
        chk("t6.new.we3", 64'(we3), 64'(1));
        chk("t6.new.wa3", 64'(wa3), 64'(7));
        chk("t6.new.wd3", 64'(wd3), 64'(32'h77));
        chk("t6.new.hit1", 64'(hit1), 64'(1));
        chk("t6.new.fwd1", 64'(fwd1), 64'(32'h77));
        tick();
        chk("t6.end.count", 64'(count), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
